reduce100_seq: RTL and testbench

//  Sequenced reduction engine: accepts one WIDTH-bit vector over a valid/ready handshake.

---
 rtl/reduce_pkg.sv | 19 +
 rtl/reduce_chunk.sv | 17 +
 rtl/reduce100_seq.sv | 148 ++++++++++++++
 tb/tb_reduce100_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// Shared types and helpers for the sequenced AND/OR/XOR reduction engine.
package reduce_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Accumulator presets: the identity element of each reduction.
    localparam logic ACC_AND_INIT = 1'b1;
    localparam logic ACC_OR_INIT  = 1'b0;
    localparam logic ACC_XOR_INIT = 1'b0;

    function automatic int nbeats(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/reduce_chunk.sv
// Combinational AND/OR/XOR of one CHUNK-bit slice; masked-off bits act as
// the identity of each reduction so padding never changes a result.
module reduce_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] data_i,
    input  logic [CHUNK-1:0] mask_i,
    output logic             and_o,
    output logic             or_o,
    output logic             xor_o
);

    assign and_o = &(data_i | ~mask_i);
    assign or_o  = |(data_i & mask_i);
    assign xor_o = ^(data_i & mask_i);

endmodule

// File: rtl/reduce100_seq.sv
// Sequenced reduction engine: captures one WIDTH-bit vector and folds it into
// AND/OR/XOR accumulators CHUNK bits per cycle through one shared reduce_chunk.
module reduce100_seq
    import reduce_pkg::*;
#(
    parameter int WIDTH = 100,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_and,
    output logic             out_or,
    output logic             out_xor,
    output logic             busy
);

    localparam int NBEATS = nbeats(WIDTH, CHUNK);
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int PADW   = NBEATS * CHUNK;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    state_e           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             drain_q, drain_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic             acc_and_q, acc_and_d;
    logic             acc_or_q, acc_or_d;
    logic             acc_xor_q, acc_xor_d;
    logic             res_and_q, res_and_d;
    logic             res_or_q, res_or_d;
    logic             res_xor_q, res_xor_d;

    logic [PADW-1:0]  vec_pad;
    int               beat_base;
    logic [CHUNK-1:0] chunk_data;
    logic [CHUNK-1:0] chunk_mask;
    logic             chunk_and, chunk_or, chunk_xor;

    assign vec_pad    = PADW'(vec_q);
    assign beat_base  = int'(beat_q) * CHUNK;
    assign chunk_data = vec_pad[beat_base +: CHUNK];

    // Bits beyond WIDTH in the last slice are masked out.
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_mask
        assign chunk_mask[gi] = (beat_base + gi) < WIDTH;
    end

    reduce_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .data_i (chunk_data),
        .mask_i (chunk_mask),
        .and_o  (chunk_and),
        .or_o   (chunk_or),
        .xor_o  (chunk_xor)
    );

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        drain_d   = drain_q;
        vec_d     = vec_q;
        acc_and_d = acc_and_q;
        acc_or_d  = acc_or_q;
        acc_xor_d = acc_xor_q;
        res_and_d = res_and_q;
        res_or_d  = res_or_q;
        res_xor_d = res_xor_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d     = in_data;
                    acc_and_d = ACC_AND_INIT;
                    acc_or_d  = ACC_OR_INIT;
                    acc_xor_d = ACC_XOR_INIT;
                    beat_d    = '0;
                    drain_d   = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (!drain_q) begin
                    acc_and_d = acc_and_q & chunk_and;
                    acc_or_d  = acc_or_q | chunk_or;
                    acc_xor_d = acc_xor_q ^ chunk_xor;
                    // Counter saturates on the last slice; drain_q marks the
                    // extra cycle that publishes the finished accumulators.
                    if (beat_q == LAST_BEAT) begin
                        drain_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else begin
                    res_and_d = acc_and_q;
                    res_or_d  = acc_or_q;
                    res_xor_d = acc_xor_q;
                    drain_d   = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            drain_q   <= 1'b0;
            vec_q     <= '0;
            acc_and_q <= ACC_AND_INIT;
            acc_or_q  <= ACC_OR_INIT;
            acc_xor_q <= ACC_XOR_INIT;
            res_and_q <= 1'b0;
            res_or_q  <= 1'b0;
            res_xor_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            drain_q   <= drain_d;
            vec_q     <= vec_d;
            acc_and_q <= acc_and_d;
            acc_or_q  <= acc_or_d;
            acc_xor_q <= acc_xor_d;
            res_and_q <= res_and_d;
            res_or_q  <= res_or_d;
            res_xor_q <= res_xor_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_and   = res_and_q;
    assign out_or    = res_or_q;
    assign out_xor   = res_xor_q;

endmodule

// File: tb/tb_reduce100_seq.sv
// Bench for reduce100_seq: four instances (CHUNK = 1, 16, 100, 128) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_reduce100_seq;

    localparam int W  = 100;
    localparam int NL = 4;
    localparam int CH  [NL] = '{1, 16, 100, 128};
    localparam int NBL [NL] = '{100, 7, 1, 1};

    logic         clk;
    logic         rst_n;
    logic         in_valid  [NL];
    logic [W-1:0] in_data   [NL];
    logic         out_ready [NL];
    logic         ir_w [NL];
    logic         ov_w [NL];
    logic         oa_w [NL];
    logic         oo_w [NL];
    logic         ox_w [NL];
    logic         bz_w [NL];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        reduce100_seq #(
            .WIDTH (W),
            .CHUNK (CH[gi])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[gi]),
            .in_ready  (ir_w[gi]),
            .in_data   (in_data[gi]),
            .out_valid (ov_w[gi]),
            .out_ready (out_ready[gi]),
            .out_and   (oa_w[gi]),
            .out_or    (oo_w[gi]),
            .out_xor   (ox_w[gi]),
            .busy      (bz_w[gi])
        );

        // Transaction model: a vector accepted at edge c yields its result
        // after edge c+NBEATS+1 and holds it until consumed.
        int       m_cyc  = 0;
        int       m_due  = 0;
        bit       m_busy = 1'b0;
        bit [2:0] m_exp  = 3'b000;
        bit [2:0] m_last = 3'b000;

        always @(posedge clk) begin
            bit ov_before;
            ov_before = m_busy && (m_cyc >= m_due);
            m_cyc++;
            if (!rst_n) begin
                m_busy = 1'b0;
                m_last = 3'b000;
                m_exp  = 3'b000;
            end else if (ov_before && out_ready[gi]) begin
                m_busy = 1'b0;
                m_last = m_exp;
            end else if (!m_busy && in_valid[gi]) begin
                m_busy = 1'b1;
                m_exp  = {&in_data[gi], |in_data[gi], ^in_data[gi]};
                m_due  = m_cyc + NBL[gi] + 1;
            end
        end

        always @(negedge clk) begin
            bit       e_ov;
            bit [2:0] e_res;
            if (rst_n === 1'b1) begin
                e_ov  = m_busy && (m_cyc >= m_due);
                e_res = e_ov ? m_exp : m_last;
                check($sformatf("L%0d out_valid cyc%0d", gi, m_cyc), 32'(ov_w[gi]), 32'(e_ov));
                check($sformatf("L%0d in_ready cyc%0d", gi, m_cyc), 32'(ir_w[gi]), 32'(!m_busy));
                check($sformatf("L%0d busy cyc%0d", gi, m_cyc), 32'(bz_w[gi]), 32'(m_busy));
                check($sformatf("L%0d result cyc%0d", gi, m_cyc),
                      32'({oa_w[gi], oo_w[gi], ox_w[gi]}), 32'(e_res));
            end
        end
    end

    // One transaction: offer v, measure accept-to-out_valid latency, optionally
    // hold off out_ready for `hold` cycles, then consume.
    task automatic run_vec(input int ln, input string tag, input logic [W-1:0] v,
                           input logic [2:0] exp, input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        check({tag, " in_ready_before"}, 32'(ir_w[ln]), 32'd1);
        in_valid[ln] = 1'b1;
        in_data[ln]  = v;
        @(posedge clk);
        @(negedge clk);
        in_valid[ln] = 1'b0;
        in_data[ln]  = ~v;
        lat = 0;
        while (!ov_w[ln] && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, 32'({oa_w[ln], oo_w[ln], ox_w[ln]}), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            check({tag, " hold out_valid"}, 32'(ov_w[ln]), 32'd1);
            check({tag, " hold in_ready"}, 32'(ir_w[ln]), 32'd0);
            check({tag, " hold result"}, 32'({oa_w[ln], oo_w[ln], ox_w[ln]}), 32'(exp));
            @(posedge clk);
            @(negedge clk);
        end
        out_ready[ln] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[ln] = 1'b0;
        check({tag, " in_ready_after"}, 32'(ir_w[ln]), 32'd1);
        check({tag, " out_valid_after"}, 32'(ov_w[ln]), 32'd0);
        check({tag, " result_kept"}, 32'({oa_w[ln], oo_w[ln], ox_w[ln]}), 32'(exp));
        $display("[TB] lane %0d %s: res=%03b lat=%0d", ln, tag,
                 {oa_w[ln], oo_w[ln], ox_w[ln]}, lat);
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] top;
        logic [W-1:0] cb;
        logic [W-1:0] v;
        logic [127:0] r;
        bit           saw;

        clk   = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < NL; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            out_ready[i] = 1'b0;
        end
        ones = '1;
        top  = '0;
        top[W-1] = 1'b1;
        cb   = {25{4'h5}};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 32'(ov_w[1]), 32'd0);
        check("reset in_ready", 32'(ir_w[1]), 32'd1);
        check("reset busy", 32'(bz_w[1]), 32'd0);
        check("reset result", 32'({oa_w[1], oo_w[1], ox_w[1]}), 32'd0);
        rst_n = 1'b1;

        run_vec(1, "all_ones", ones, 3'b110, 8, 0);
        run_vec(1, "zero", '0, 3'b000, 8, 0);
        run_vec(1, "bit99", top, 3'b011, 8, 0);
        run_vec(1, "checker", cb, 3'b010, 8, 0);
        v = cb;
        v[0] = 1'b0;
        run_vec(1, "checker_flip0", v, 3'b011, 8, 0);
        run_vec(1, "backpressure", cb, 3'b010, 8, 5);

        // Abort a vector while beat 3 is being reduced.
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_data[1]  = ones;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort busy_before", 32'(bz_w[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(ov_w[1]), 32'd0);
        check("abort busy", 32'(bz_w[1]), 32'd0);
        check("abort in_ready", 32'(ir_w[1]), 32'd1);
        check("abort result", 32'({oa_w[1], oo_w[1], ox_w[1]}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release in_ready", 32'(ir_w[1]), 32'd1);
        saw = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ov_w[1]) saw = 1'b1;
        end
        check("abort no_out_valid", 32'(saw), 32'd0);
        $display("[TB] lane 1 abort: out_valid seen=%0d", saw);

        // Sweep every CHUNK instance with boundary and random vectors.
        for (int ln = 0; ln < NL; ln++) begin
            for (int k = 0; k < 5; k++) begin
                r = {$urandom, $urandom, $urandom, $urandom};
                case (k)
                    0: v = ones;
                    1: v = top;
                    2: begin v = ones; v[57] = 1'b0; end
                    default: v = r[W-1:0];
                endcase
                run_vec(ln, $sformatf("sweep_c%0d_%0d", CH[ln], k), v,
                        {&v, |v, ^v}, NBL[ln] + 1, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
